// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with optional hard-wired zero
// entry, optional write-to-read bypass and a one-entry-per-cycle clear engine.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  output logic              we_rdy,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              clr,
  output logic              busy
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_idx, clr_idx_nxt;
  logic              wr_acc;
  logic [DATA_W-1:0] mem [DEPTH];

  // State register and clear index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // Next state and handshake; clr wins over a same-cycle write
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    busy        = 1'b0;
    we_rdy      = 1'b0;
    wr_acc      = 1'b0;
    case (state)
      IDLE: begin
        we_rdy = ~clr;
        wr_acc = we & ~clr;
        if (clr) begin
          state_nxt   = CLEAR;
          clr_idx_nxt = '0;
        end
      end
      CLEAR: begin
        busy        = 1'b1;
        clr_idx_nxt = clr_idx + ADDR_W'(1);
        if (clr_idx == LAST_IDX) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage array: zeroed by reset and by the clear engine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (wr_acc && !(ZERO_REG && (waddr == '0))) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port 1: zero entry overrides bypass, bypass overrides storage
  always_comb begin
    rdata1 = mem[raddr1];
    if (BYPASS && wr_acc && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
    if (ZERO_REG && (raddr1 == '0)) begin
      rdata1 = '0;
    end
  end

  // Read port 2: same priority as port 1
  always_comb begin
    rdata2 = mem[raddr2];
    if (BYPASS && wr_acc && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
    if (ZERO_REG && (raddr2 == '0)) begin
      rdata2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations driven side by side and
// compared against an array-based model of the register file behaviour.
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        we, clr;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata;
  logic        we_rdy0, busy0, we_rdy1, busy1;
  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;

  logic        we_s, clr_s;
  logic [2:0]  waddr_s, raddr1_s, raddr2_s;
  logic [7:0]  wdata_s, rd1_2, rd2_2;
  logic        we_rdy2, busy2;

  // k=0: defaults (zero reg, bypass); k=1: plain register 0, no bypass; k=2: 8x8
  regfile_param dut0 (
    .clk(clk), .rst(rst), .we(we), .we_rdy(we_rdy0), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_0), .rdata2(rd2_0),
    .clr(clr), .busy(busy0));

  regfile_param #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
    .clk(clk), .rst(rst), .we(we), .we_rdy(we_rdy1), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_1), .rdata2(rd2_1),
    .clr(clr), .busy(busy1));

  regfile_param #(.DATA_W(8), .ADDR_W(3)) dut2 (
    .clk(clk), .rst(rst), .we(we_s), .we_rdy(we_rdy2), .waddr(waddr_s), .wdata(wdata_s),
    .raddr1(raddr1_s), .raddr2(raddr2_s), .rdata1(rd1_2), .rdata2(rd2_2),
    .clr(clr_s), .busy(busy2));

  // Reference model: contents per configuration, and cycles elapsed in a clear (-1 = none)
  logic [31:0] m [3][32];
  int          el [3];
  int          depth [3] = '{32, 32, 8};
  bit          zr [3]    = '{1'b1, 1'b0, 1'b1};
  bit          bp [3]    = '{1'b1, 1'b0, 1'b1};

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic in_we(int k);
    return (k == 2) ? we_s : we;
  endfunction

  function automatic logic in_clr(int k);
    return (k == 2) ? clr_s : clr;
  endfunction

  function automatic int in_waddr(int k);
    return (k == 2) ? int'(waddr_s) : int'(waddr);
  endfunction

  function automatic logic [31:0] in_wdata(int k);
    return (k == 2) ? {24'b0, wdata_s} : wdata;
  endfunction

  function automatic int in_raddr(int k, int p);
    if (k == 2) return (p == 1) ? int'(raddr1_s) : int'(raddr2_s);
    return (p == 1) ? int'(raddr1) : int'(raddr2);
  endfunction

  function automatic logic [31:0] act_rd(int k, int p);
    case (k)
      0:       return (p == 1) ? rd1_0 : rd2_0;
      1:       return (p == 1) ? rd1_1 : rd2_1;
      default: return (p == 1) ? {24'b0, rd1_2} : {24'b0, rd2_2};
    endcase
  endfunction

  function automatic logic act_busy(int k);
    return (k == 0) ? busy0 : (k == 1) ? busy1 : busy2;
  endfunction

  function automatic logic act_rdy(int k);
    return (k == 0) ? we_rdy0 : (k == 1) ? we_rdy1 : we_rdy2;
  endfunction

  function automatic logic exp_busy(int k);
    return el[k] >= 0;
  endfunction

  function automatic logic exp_rdy(int k);
    return (el[k] < 0) && !in_clr(k);
  endfunction

  function automatic logic [31:0] exp_rd(int k, int a);
    logic acc;
    acc = (el[k] < 0) && in_we(k) && !in_clr(k);
    if (zr[k] && a == 0) return 32'h0;
    if (bp[k] && acc && in_waddr(k) == a) return in_wdata(k);
    return m[k][a];
  endfunction

  function automatic void mdl_reset();
    for (int k = 0; k < 3; k++) begin
      el[k] = -1;
      for (int a = 0; a < 32; a++) m[k][a] = 32'h0;
    end
  endfunction

  // Effect of one rising edge, using the inputs present before it
  function automatic void mdl_edge();
    for (int k = 0; k < 3; k++) begin
      if (el[k] >= 0) begin
        m[k][el[k]] = 32'h0;
        el[k]++;
        if (el[k] == depth[k]) el[k] = -1;
      end else if (in_clr(k)) begin
        el[k] = 0;
      end else if (in_we(k) && !(zr[k] && in_waddr(k) == 0)) begin
        m[k][in_waddr(k)] = in_wdata(k);
      end
    end
  endfunction

  task automatic tick();
    if (rst) mdl_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; clr = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    we_s = 1'b0; clr_s = 1'b0; waddr_s = '0; wdata_s = '0; raddr1_s = '0; raddr2_s = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (act_busy(k) !== 1'b0) begin
        n_bad++; $display("FAIL reset_busy k=%0d: got %b want 0", k, act_busy(k));
      end
      n_cmp++;
      if (act_rdy(k) !== 1'b1) begin
        n_bad++; $display("FAIL reset_we_rdy k=%0d: got %b want 1", k, act_rdy(k));
      end
    end
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      raddr1_s = 3'(a); raddr2_s = 3'(7 - (a % 8));
      #1;
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (act_rd(k, 1) !== 32'h0 || act_rd(k, 2) !== 32'h0) begin
          n_bad++;
          $display("FAIL reset_read k=%0d a=%0d: got %h/%h want 0", k, a, act_rd(k, 1), act_rd(k, 2));
        end
      end
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    n_cmp++;
    if (rd1_0 !== 32'hDEADBEEF || rd2_0 !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL wr_rd_5: got %h/%h want deadbeef", rd1_0, rd2_0);
    end
    n_cmp++;
    if (rd1_1 !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL wr_rd_5_nobyp: got %h want deadbeef", rd1_1);
    end
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    tick();
    we = 1'b0; raddr1 = 5'd0;
    #1;
    n_cmp++;
    if (rd1_0 !== 32'h0) begin
      n_bad++; $display("FAIL zero_reg: got %h want 0", rd1_0);
    end
    n_cmp++;
    if (rd1_1 !== 32'h12345678) begin
      n_bad++; $display("FAIL plain_reg0: got %h want 12345678", rd1_1);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] old1;
    old1 = m[1][7];
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr1 = 5'd7;
    #1;
    n_cmp++;
    if (rd1_0 !== 32'hA5A5A5A5) begin
      n_bad++; $display("FAIL bypass_same_cycle: got %h want a5a5a5a5", rd1_0);
    end
    n_cmp++;
    if (rd1_1 !== old1) begin
      n_bad++; $display("FAIL nobypass_same_cycle: got %h want %h", rd1_1, old1);
    end
    tick();
    we = 1'b0;
    #1;
    n_cmp++;
    if (rd1_1 !== 32'hA5A5A5A5) begin
      n_bad++; $display("FAIL nobypass_next_cycle: got %h want a5a5a5a5", rd1_1);
    end
  endtask

  task automatic test_clear();
    int cnt0, cnt2;
    for (int a = 0; a < 32; a++) begin
      we = 1'b1; waddr = 5'(a); wdata = 32'(a);
      we_s = 1'b1; waddr_s = 3'(a); wdata_s = 8'(a % 8);
      tick();
    end
    clr = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h0000DEAD;
    clr_s = 1'b1; we_s = 1'b0;
    #1;
    n_cmp++;
    if (we_rdy0 !== 1'b0 || we_rdy2 !== 1'b0) begin
      n_bad++; $display("FAIL clr_blocks_we: got %b/%b want 0/0", we_rdy0, we_rdy2);
    end
    tick();
    clr = 1'b0; clr_s = 1'b0;
    cnt0 = 0; cnt2 = 0;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1)); waddr = 5'($urandom); wdata = $urandom;
      we_s = 1'($urandom_range(0, 1)); waddr_s = 3'($urandom); wdata_s = 8'($urandom);
      raddr1 = (i == 0) ? 5'd3 : 5'd2; raddr2 = 5'd30;
      raddr1_s = 3'($urandom); raddr2_s = 3'($urandom);
      #1;
      if (i == 0) begin
        n_cmp++;
        if (rd1_0 !== 32'd3) begin
          n_bad++; $display("FAIL clr_write_dropped: got %h want 3", rd1_0);
        end
      end
      if (i == 10) begin
        n_cmp++;
        if (rd1_0 !== 32'h0 || rd1_1 !== 32'h0) begin
          n_bad++; $display("FAIL mid_clear_e2: got %h/%h want 0", rd1_0, rd1_1);
        end
        n_cmp++;
        if (rd2_0 !== 32'd30 || rd2_1 !== 32'd30) begin
          n_bad++; $display("FAIL mid_clear_e30: got %h/%h want 1e", rd2_0, rd2_1);
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (act_rd(k, 2) !== exp_rd(k, in_raddr(k, 2)) || act_busy(k) !== exp_busy(k)) begin
          n_bad++;
          $display("FAIL clear_model k=%0d i=%0d: got %h busy %b want %h busy %b", k, i,
                   act_rd(k, 2), act_busy(k), exp_rd(k, in_raddr(k, 2)), exp_busy(k));
        end
      end
      if (busy0) cnt0++;
      if (busy2) cnt2++;
      if (!busy0 && !busy2) break;
      tick();
    end
    n_cmp++;
    if (cnt0 !== 32) begin
      n_bad++; $display("FAIL busy_len_32: got %0d want 32", cnt0);
    end
    n_cmp++;
    if (cnt2 !== 8) begin
      n_bad++; $display("FAIL busy_len_8: got %0d want 8", cnt2);
    end
    we = 1'b0; we_s = 1'b0;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a);
      #1;
      n_cmp++;
      if (rd1_0 !== 32'h0 || rd1_1 !== 32'h0) begin
        n_bad++; $display("FAIL after_clear a=%0d: got %h/%h want 0", a, rd1_0, rd1_1);
      end
    end
  endtask

  task automatic test_small_wrap();
    int cnt;
    we = 1'b0; clr = 1'b0;
    we_s = 1'b1; waddr_s = 3'd7; wdata_s = 8'hFF;
    tick();
    we_s = 1'b0; raddr1_s = 3'd7;
    #1;
    n_cmp++;
    if (rd1_2 !== 8'hFF) begin
      n_bad++; $display("FAIL small_wr_rd7: got %h want ff", rd1_2);
    end
    for (int r = 0; r < 2; r++) begin
      clr_s = 1'b1;
      tick();
      clr_s = 1'b0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
        #1;
        if (i == 3) begin
          n_cmp++;
          if (rd1_2 !== ((r == 0) ? 8'hFF : 8'h00)) begin
            n_bad++; $display("FAIL small_mid_clear r=%0d: got %h", r, rd1_2);
          end
        end
        if (!busy2) break;
        cnt++;
        tick();
      end
      n_cmp++;
      if (cnt !== 8 || we_rdy2 !== 1'b1) begin
        n_bad++; $display("FAIL small_clear_len r=%0d: got %0d rdy %b want 8 rdy 1", r, cnt, we_rdy2);
      end
    end
    for (int a = 0; a < 8; a++) begin
      raddr1_s = 3'(a);
      #1;
      n_cmp++;
      if (rd1_2 !== 8'h00) begin
        n_bad++; $display("FAIL small_after_clear a=%0d: got %h want 0", a, rd1_2);
      end
    end
    we_s = 1'b1; waddr_s = 3'd7; wdata_s = 8'h3C;
    tick();
    we_s = 1'b0; raddr1_s = 3'd7;
    #1;
    n_cmp++;
    if (rd1_2 !== 8'h3C) begin
      n_bad++; $display("FAIL small_post_wrap_wr: got %h want 3c", rd1_2);
    end
  endtask

  task automatic test_reset_mid_clear();
    idle_inputs();
    we = 1'b1; waddr = 5'd20; wdata = 32'h55555555;
    tick();
    we = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    rst = 1'b0;
    mdl_reset();
    #1;
    n_cmp++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_clear_busy: got %b%b%b want 000", busy0, busy1, busy2);
    end
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a);
      #1;
      n_cmp++;
      if (rd1_0 !== 32'h0 || rd1_1 !== 32'h0) begin
        n_bad++; $display("FAIL rst_mid_clear_rd a=%0d: got %h/%h want 0", a, rd1_0, rd1_1);
      end
    end
    tick();
    rst = 1'b1;
    we = 1'b1; waddr = 5'd9; wdata = 32'h99990009;
    #1;
    n_cmp++;
    if (we_rdy0 !== 1'b1) begin
      n_bad++; $display("FAIL post_rst_rdy: got %b want 1", we_rdy0);
    end
    tick();
    we = 1'b0; raddr1 = 5'd9;
    #1;
    n_cmp++;
    if (rd1_0 !== 32'h99990009 || rd1_1 !== 32'h99990009) begin
      n_bad++; $display("FAIL post_rst_wr9: got %h/%h want 99990009", rd1_0, rd1_1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1)); waddr = 5'($urandom); wdata = $urandom;
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      raddr2 = 5'($urandom);
      clr = ($urandom_range(0, 59) == 0);
      we_s = 1'($urandom_range(0, 1)); waddr_s = 3'($urandom); wdata_s = 8'($urandom);
      raddr1_s = ($urandom_range(0, 3) == 0) ? waddr_s : 3'($urandom);
      raddr2_s = 3'($urandom);
      clr_s = ($urandom_range(0, 29) == 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (act_rd(k, 1) !== exp_rd(k, in_raddr(k, 1))) begin
          n_bad++; $display("FAIL rand_rd1 k=%0d i=%0d: got %h want %h", k, i,
                            act_rd(k, 1), exp_rd(k, in_raddr(k, 1)));
        end
        n_cmp++;
        if (act_rd(k, 2) !== exp_rd(k, in_raddr(k, 2))) begin
          n_bad++; $display("FAIL rand_rd2 k=%0d i=%0d: got %h want %h", k, i,
                            act_rd(k, 2), exp_rd(k, in_raddr(k, 2)));
        end
        n_cmp++;
        if (act_busy(k) !== exp_busy(k) || act_rdy(k) !== exp_rdy(k)) begin
          n_bad++; $display("FAIL rand_hs k=%0d i=%0d: got busy %b rdy %b want busy %b rdy %b",
                            k, i, act_busy(k), act_rdy(k), exp_busy(k), exp_rdy(k));
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_small_wrap();
    test_reset_mid_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1);
  end

endmodule
